// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
// Shared definitions for the ID/EX forwarding and hazard controller:
//   - operand-select codes driven onto the 5-input forwarding muxes
//   - width of the select code
//   - divider sequencing FSM state encoding
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

    localparam int SEL_W = 3;

    localparam logic [SEL_W-1:0] SEL_RF      = 3'b111;
    localparam logic [SEL_W-1:0] SEL_EX      = 3'b110;
    localparam logic [SEL_W-1:0] SEL_MEM_ALU = 3'b101;
    localparam logic [SEL_W-1:0] SEL_MEM_LD  = 3'b100;
    localparam logic [SEL_W-1:0] SEL_WB      = 3'b011;

    typedef enum logic {
        DIV_IDLE = 1'b0,
        DIV_BUSY = 1'b1
    } div_state_t;

endpackage

// File: rtl/fwd_src_select.sv
// ---------------------------------------------------------------------------
// fwd_src_select
// Combinational bypass-source picker for one ID operand. Compares the source
// register against the EX, MEM and WB stage records and returns the select
// code of the youngest matching producer, or flags a load-use hazard when
// the youngest producer is a load still in EX.
//
// Ports
//   src          in   REG_AW  source register index
//   rd_en        in   1       operand is actually read (use flag & ID valid)
//   ex_valid     in   1       EX record fields
//   ex_wen       in   1
//   ex_dst       in   REG_AW
//   ex_is_load   in   1
//   mem_valid    in   1       MEM record fields
//   mem_wen      in   1
//   mem_dst      in   REG_AW
//   mem_is_load  in   1
//   wb_valid     in   1       WB record fields
//   wb_wen       in   1
//   wb_dst       in   REG_AW
//   sel          out  3       operand mux select
//   load_use     out  1       youngest producer is a load in EX
// ---------------------------------------------------------------------------
module fwd_src_select
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic              rd_en,
    input  logic              ex_valid,
    input  logic              ex_wen,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_is_load,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_is_load,
    input  logic              wb_valid,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_dst,
    output logic [SEL_W-1:0]  sel,
    output logic              load_use
);

    logic src_live;
    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    // Register 0 is hard-wired, so a write to it is never a real producer.
    assign src_live = rd_en & (src != '0);

    assign hit_ex  = src_live & ex_valid  & ex_wen  & (ex_dst  == src);
    assign hit_mem = src_live & mem_valid & mem_wen & (mem_dst == src);
    assign hit_wb  = src_live & wb_valid  & wb_wen  & (wb_dst  == src);

    always_comb begin
        sel      = SEL_RF;
        load_use = 1'b0;
        if (hit_ex) begin
            // Load data does not exist until the end of MEM; hold the
            // consumer and leave the mux on the regfile while it waits.
            if (ex_is_load) begin
                load_use = 1'b1;
            end else begin
                sel = SEL_EX;
            end
        end else if (hit_mem) begin
            sel = mem_is_load ? SEL_MEM_LD : SEL_MEM_ALU;
        end else if (hit_wb) begin
            sel = SEL_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding and hazard controller for the in-order pipeline ID/EX operand
// path. Keeps a small record of the register write carried by each of
// EX, MEM and WB, derives the rs/rt bypass selects, and raises stall_id for
// load-use hazards and while the multi-cycle divider is occupied.
//
// Ports
//   clk         in   1       core clock
//   rst         in   1       synchronous reset, active-high
//   ext_stall   in   1       global freeze; stage records hold
//   id_valid    in   1       instruction present in ID
//   id_rs       in   REG_AW  source register 1
//   id_rt       in   REG_AW  source register 2
//   id_use_rs   in   1       instruction reads rs
//   id_use_rt   in   1       instruction reads rt
//   id_wen      in   1       instruction writes a GPR
//   id_wdst     in   REG_AW  destination GPR
//   id_is_load  in   1       instruction is a load
//   id_is_div   in   1       instruction starts the divider
//   rs_sel      out  3       rs operand mux select
//   rt_sel      out  3       rt operand mux select
//   stall_id    out  1       hold PC and IF/ID, bubble into EX
//   div_busy    out  1       divider occupied
//
// Divider FSM
//   state    | meaning
//   ---------+------------------------------------------------------------
//   DIV_IDLE | divider free; a divide in ID may issue
//   DIV_BUSY | divider occupied; div_cnt counts down the remaining cycles,
//            | leaves on terminal count 0 (ext_stall does not pause it)
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wen,
    input  logic [REG_AW-1:0] id_wdst,
    input  logic              id_is_load,
    input  logic              id_is_div,
    output logic [SEL_W-1:0]  rs_sel,
    output logic [SEL_W-1:0]  rt_sel,
    output logic              stall_id,
    output logic              div_busy
);

    localparam int              CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    // Stage records. WB carries no load flag: its value is final either way.
    logic              ex_valid_q,  ex_wen_q,  ex_is_load_q;
    logic [REG_AW-1:0] ex_dst_q;
    logic              mem_valid_q, mem_wen_q, mem_is_load_q;
    logic [REG_AW-1:0] mem_dst_q;
    logic              wb_valid_q,  wb_wen_q;
    logic [REG_AW-1:0] wb_dst_q;

    div_state_t        div_state_q, div_state_d;
    logic [CNT_W-1:0]  div_cnt_q,   div_cnt_d;

    logic              rs_load_use;
    logic              rt_load_use;
    logic              div_hold;
    logic              div_issue;

    fwd_src_select #(.REG_AW(REG_AW)) u_rs_select (
        .src         (id_rs),
        .rd_en       (id_valid & id_use_rs),
        .ex_valid    (ex_valid_q),
        .ex_wen      (ex_wen_q),
        .ex_dst      (ex_dst_q),
        .ex_is_load  (ex_is_load_q),
        .mem_valid   (mem_valid_q),
        .mem_wen     (mem_wen_q),
        .mem_dst     (mem_dst_q),
        .mem_is_load (mem_is_load_q),
        .wb_valid    (wb_valid_q),
        .wb_wen      (wb_wen_q),
        .wb_dst      (wb_dst_q),
        .sel         (rs_sel),
        .load_use    (rs_load_use)
    );

    fwd_src_select #(.REG_AW(REG_AW)) u_rt_select (
        .src         (id_rt),
        .rd_en       (id_valid & id_use_rt),
        .ex_valid    (ex_valid_q),
        .ex_wen      (ex_wen_q),
        .ex_dst      (ex_dst_q),
        .ex_is_load  (ex_is_load_q),
        .mem_valid   (mem_valid_q),
        .mem_wen     (mem_wen_q),
        .mem_dst     (mem_dst_q),
        .mem_is_load (mem_is_load_q),
        .wb_valid    (wb_valid_q),
        .wb_wen      (wb_wen_q),
        .wb_dst      (wb_dst_q),
        .sel         (rt_sel),
        .load_use    (rt_load_use)
    );

    assign div_busy = (div_state_q == DIV_BUSY);
    assign div_hold = div_busy & id_valid;
    assign stall_id = rs_load_use | rt_load_use | div_hold;

    // A divide held by a load-use stall is simply retried once the stall
    // clears; stall_id already covers the BUSY case so no re-issue occurs.
    assign div_issue = id_valid & id_is_div & ~stall_id & ~ext_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_wen_q      <= 1'b0;
            ex_dst_q      <= '0;
            ex_is_load_q  <= 1'b0;
            mem_valid_q   <= 1'b0;
            mem_wen_q     <= 1'b0;
            mem_dst_q     <= '0;
            mem_is_load_q <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_wen_q      <= 1'b0;
            wb_dst_q      <= '0;
        end else if (!ext_stall) begin
            wb_valid_q    <= mem_valid_q;
            wb_wen_q      <= mem_wen_q;
            wb_dst_q      <= mem_dst_q;
            mem_valid_q   <= ex_valid_q;
            mem_wen_q     <= ex_wen_q;
            mem_dst_q     <= ex_dst_q;
            mem_is_load_q <= ex_is_load_q;
            if (stall_id || !id_valid) begin
                ex_valid_q   <= 1'b0;
                ex_wen_q     <= 1'b0;
                ex_dst_q     <= '0;
                ex_is_load_q <= 1'b0;
            end else begin
                ex_valid_q   <= 1'b1;
                ex_wen_q     <= id_wen;
                ex_dst_q     <= id_wdst;
                ex_is_load_q <= id_is_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state_q <= DIV_IDLE;
            div_cnt_q   <= '0;
        end else begin
            div_state_q <= div_state_d;
            div_cnt_q   <= div_cnt_d;
        end
    end

    always_comb begin
        div_state_d = div_state_q;
        div_cnt_d   = div_cnt_q;
        case (div_state_q)
            DIV_IDLE: begin
                if (div_issue) begin
                    div_state_d = DIV_BUSY;
                    div_cnt_d   = CNT_LOAD;
                end
            end
            DIV_BUSY: begin
                if (div_cnt_q == '0) begin
                    div_state_d = DIV_IDLE;
                end else begin
                    div_cnt_d = div_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                div_state_d = DIV_IDLE;
                div_cnt_d   = '0;
            end
        endcase
    end

endmodule
